// File: rtl/mem_arbiter.sv
// Request scheduler between fetch / load-store buffer and the byte-serial memory controller.
// Optional fetch aging (anti-starvation) is enabled by defining MEM_ARB_AGING_EN.
module mem_arbiter #(
   parameter int AGE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        lsb_req,
   input  logic        lsb_wr,
   input  logic [31:0] lsb_addr,
   input  logic [2:0]  lsb_len,
   input  logic [31:0] lsb_wdata,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata,
   output logic        mc_if_en,
   output logic [31:0] mc_if_pc,
   input  logic        mc_if_done,
   input  logic [31:0] mc_if_data,
   output logic        mc_lsb_en,
   output logic        mc_lsb_wr,
   output logic [31:0] mc_lsb_addr,
   output logic [2:0]  mc_lsb_len,
   output logic [31:0] mc_lsb_w_data,
   input  logic        mc_lsb_done,
   input  logic [31:0] mc_lsb_r_data
);

   if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_bad_age_limit
      $error("mem_arbiter: AGE_LIMIT must be in 1..15");
   end

   typedef enum logic [2:0] {
      IDLE,
      BUSY_IF,
      BUSY_LD,
      BUSY_ST,
      DISCARD_IF,
      RESP
   } state_t;

   state_t      state_reg, state_next;
   logic        mc_if_en_reg, mc_if_en_next;
   logic [31:0] mc_if_pc_reg, mc_if_pc_next;
   logic        mc_lsb_en_reg, mc_lsb_en_next;
   logic        mc_lsb_wr_reg, mc_lsb_wr_next;
   logic [31:0] mc_lsb_addr_reg, mc_lsb_addr_next;
   logic [2:0]  mc_lsb_len_reg, mc_lsb_len_next;
   logic [31:0] mc_lsb_w_data_reg, mc_lsb_w_data_next;
   logic        if_done_reg, if_done_next;
   logic [31:0] if_data_reg, if_data_next;
   logic        lsb_done_reg, lsb_done_next;
   logic [31:0] lsb_rdata_reg, lsb_rdata_next;
   logic        force_if;

`ifdef MEM_ARB_AGING_EN
   logic [3:0]  age_reg, age_next;
   assign force_if = if_req && (age_reg == 4'(AGE_LIMIT));
`else
   assign force_if = 1'b0;
`endif

   // Load data arrives as raw bytes; anything above the requested length is cleared.
   function automatic logic [31:0] mask_len(input logic [31:0] d, input logic [2:0] len);
      case (len)
         3'd1:    mask_len = {24'h0, d[7:0]};
         3'd2:    mask_len = {16'h0, d[15:0]};
         default: mask_len = d;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         mc_if_en_reg      <= 1'b0;
         mc_if_pc_reg      <= '0;
         mc_lsb_en_reg     <= 1'b0;
         mc_lsb_wr_reg     <= 1'b0;
         mc_lsb_addr_reg   <= '0;
         mc_lsb_len_reg    <= '0;
         mc_lsb_w_data_reg <= '0;
         if_done_reg       <= 1'b0;
         if_data_reg       <= '0;
         lsb_done_reg      <= 1'b0;
         lsb_rdata_reg     <= '0;
`ifdef MEM_ARB_AGING_EN
         age_reg           <= '0;
`endif
      end else if (rdy) begin
         state_reg         <= state_next;
         mc_if_en_reg      <= mc_if_en_next;
         mc_if_pc_reg      <= mc_if_pc_next;
         mc_lsb_en_reg     <= mc_lsb_en_next;
         mc_lsb_wr_reg     <= mc_lsb_wr_next;
         mc_lsb_addr_reg   <= mc_lsb_addr_next;
         mc_lsb_len_reg    <= mc_lsb_len_next;
         mc_lsb_w_data_reg <= mc_lsb_w_data_next;
         if_done_reg       <= if_done_next;
         if_data_reg       <= if_data_next;
         lsb_done_reg      <= lsb_done_next;
         lsb_rdata_reg     <= lsb_rdata_next;
`ifdef MEM_ARB_AGING_EN
         age_reg           <= age_next;
`endif
      end
   end

   always_comb begin
      state_next         = state_reg;
      mc_if_en_next      = mc_if_en_reg;
      mc_if_pc_next      = mc_if_pc_reg;
      mc_lsb_en_next     = mc_lsb_en_reg;
      mc_lsb_wr_next     = mc_lsb_wr_reg;
      mc_lsb_addr_next   = mc_lsb_addr_reg;
      mc_lsb_len_next    = mc_lsb_len_reg;
      mc_lsb_w_data_next = mc_lsb_w_data_reg;
      if_done_next       = 1'b0;
      if_data_next       = if_data_reg;
      lsb_done_next      = 1'b0;
      lsb_rdata_next     = lsb_rdata_reg;
`ifdef MEM_ARB_AGING_EN
      age_next           = age_reg;
`endif

      case (state_reg)
         IDLE: begin
`ifdef MEM_ARB_AGING_EN
            if (!if_req) age_next = '0;
`endif
            if (!rollback) begin
               if (lsb_req && !force_if) begin
                  mc_lsb_en_next     = 1'b1;
                  mc_lsb_wr_next     = lsb_wr;
                  mc_lsb_addr_next   = lsb_addr;
                  mc_lsb_len_next    = lsb_len;
                  mc_lsb_w_data_next = lsb_wdata;
                  state_next         = lsb_wr ? BUSY_ST : BUSY_LD;
`ifdef MEM_ARB_AGING_EN
                  if (if_req) age_next = age_reg + 4'd1;
`endif
               end else if (if_req) begin
                  mc_if_en_next = 1'b1;
                  mc_if_pc_next = if_addr;
                  state_next    = BUSY_IF;
`ifdef MEM_ARB_AGING_EN
                  age_next      = '0;
`endif
               end
            end
         end
         BUSY_IF: begin
            // A flush coinciding with completion drops the word just like DISCARD_IF would.
            if (mc_if_done) begin
               mc_if_en_next = 1'b0;
               state_next    = RESP;
               if (!rollback) begin
                  if_data_next = mc_if_data;
                  if_done_next = 1'b1;
               end
            end else if (rollback) begin
               state_next = DISCARD_IF;
            end
         end
         BUSY_LD: begin
            if (rollback) begin
               mc_lsb_en_next = 1'b0;
               state_next     = IDLE;
            end else if (mc_lsb_done) begin
               mc_lsb_en_next = 1'b0;
               lsb_rdata_next = mask_len(mc_lsb_r_data, mc_lsb_len_reg);
               lsb_done_next  = 1'b1;
               state_next     = RESP;
            end
         end
         BUSY_ST: begin
            // Stores are architecturally committed, so rollback never touches them.
            if (mc_lsb_done) begin
               mc_lsb_en_next = 1'b0;
               lsb_done_next  = 1'b1;
               state_next     = RESP;
            end
         end
         DISCARD_IF: begin
            if (mc_if_done) begin
               mc_if_en_next = 1'b0;
               state_next    = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign if_done       = if_done_reg;
   assign if_data       = if_data_reg;
   assign lsb_done      = lsb_done_reg;
   assign lsb_rdata     = lsb_rdata_reg;
   assign mc_if_en      = mc_if_en_reg;
   assign mc_if_pc      = mc_if_pc_reg;
   assign mc_lsb_en     = mc_lsb_en_reg;
   assign mc_lsb_wr     = mc_lsb_wr_reg;
   assign mc_lsb_addr   = mc_lsb_addr_reg;
   assign mc_lsb_len    = mc_lsb_len_reg;
   assign mc_lsb_w_data = mc_lsb_w_data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, done timing, rollback cases, rdy freeze, aging.
// Expected grant order follows MEM_ARB_AGING_EN when the bench is built with it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic        if_req, if_done, lsb_req, lsb_wr, lsb_done;
   logic [31:0] if_addr, if_data, lsb_addr, lsb_wdata, lsb_rdata;
   logic [2:0]  lsb_len, mc_lsb_len;
   logic        mc_if_en, mc_if_done, mc_lsb_en, mc_lsb_wr, mc_lsb_done;
   logic [31:0] mc_if_pc, mc_if_data, mc_lsb_addr, mc_lsb_w_data, mc_lsb_r_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AGE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mc_if_en(mc_if_en), .mc_if_pc(mc_if_pc), .mc_if_done(mc_if_done), .mc_if_data(mc_if_data),
      .mc_lsb_en(mc_lsb_en), .mc_lsb_wr(mc_lsb_wr), .mc_lsb_addr(mc_lsb_addr),
      .mc_lsb_len(mc_lsb_len), .mc_lsb_w_data(mc_lsb_w_data),
      .mc_lsb_done(mc_lsb_done), .mc_lsb_r_data(mc_lsb_r_data)
   );

   // Advance one clock; all drives and checks happen 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [9:0] exp_f;
      int         waited;
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      if_req = 1'b0; if_addr = '0;
      lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_wdata = '0;
      mc_if_done = 1'b0; mc_if_data = '0; mc_lsb_done = 1'b0; mc_lsb_r_data = '0;
      step(); step();
      rst = 1'b0;

      // Reset state
      chk("rst_mc_if_en", 32'(mc_if_en), 32'd0);
      chk("rst_mc_lsb_en", 32'(mc_lsb_en), 32'd0);
      chk("rst_if_done", 32'(if_done), 32'd0);
      chk("rst_lsb_done", 32'(lsb_done), 32'd0);
      chk("rst_if_data", if_data, 32'h0);
      chk("rst_lsb_rdata", lsb_rdata, 32'h0);
      chk("rst_mc_if_pc", mc_if_pc, 32'h0);
      chk("rst_mc_lsb_addr", mc_lsb_addr, 32'h0);
      chk("rst_mc_lsb_len", 32'(mc_lsb_len), 32'd0);
      chk("rst_mc_lsb_wdata", mc_lsb_w_data, 32'h0);

      // Plain fetch
      if_req = 1'b1; if_addr = 32'h1000;
      step();
      chk("f1_grant_en", 32'(mc_if_en), 32'd1);
      chk("f1_grant_pc", mc_if_pc, 32'h1000);
      step();
      chk("f1_wait_done", 32'(if_done), 32'd0);
      mc_if_done = 1'b1; mc_if_data = 32'hDEADBEEF;
      step();
      mc_if_done = 1'b0; mc_if_data = 32'h0;
      chk("f1_done", 32'(if_done), 32'd1);
      chk("f1_data", if_data, 32'hDEADBEEF);
      chk("f1_en_drop", 32'(mc_if_en), 32'd0);
      if_req = 1'b0;
      step();
      chk("f1_done_pulse", 32'(if_done), 32'd0);
      chk("f1_data_hold", if_data, 32'hDEADBEEF);

      // Simultaneous requests: half-word load first, then fetch at D+2
      if_req = 1'b1; if_addr = 32'h2000;
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h20; lsb_len = 3'd2;
      step();
      chk("pri_lsb_en", 32'(mc_lsb_en), 32'd1);
      chk("pri_if_en", 32'(mc_if_en), 32'd0);
      chk("pri_addr", mc_lsb_addr, 32'h20);
      chk("pri_len", 32'(mc_lsb_len), 32'd2);
      chk("pri_wr", 32'(mc_lsb_wr), 32'd0);
      step();
      mc_lsb_done = 1'b1; mc_lsb_r_data = 32'hDDCCBBAA;
      step();
      mc_lsb_done = 1'b0; mc_lsb_r_data = 32'h0;
      chk("ld2_done", 32'(lsb_done), 32'd1);
      chk("ld2_rdata", lsb_rdata, 32'h0000BBAA);
      chk("ld2_no_if_resp", 32'(mc_if_en), 32'd0);
      lsb_req = 1'b0;
      step();
      chk("ld2_pulse", 32'(lsb_done), 32'd0);
      chk("ld2_no_if_d1", 32'(mc_if_en), 32'd0);
      step();
      chk("f2_grant_d2", 32'(mc_if_en), 32'd1);
      chk("f2_pc", mc_if_pc, 32'h2000);
      mc_if_done = 1'b1; mc_if_data = 32'h11223344;
      step();
      mc_if_done = 1'b0;
      chk("f2_data", if_data, 32'h11223344);
      if_req = 1'b0;
      step();

      // Rollback during a word load, then a normal fetch
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h40; lsb_len = 3'd4;
      step();
      chk("rbl_grant", 32'(mc_lsb_en), 32'd1);
      rollback = 1'b1;
      step();
      rollback = 1'b0; lsb_req = 1'b0;
      chk("rbl_en_drop", 32'(mc_lsb_en), 32'd0);
      chk("rbl_no_done", 32'(lsb_done), 32'd0);
      if_req = 1'b1; if_addr = 32'h3000;
      step();
      chk("rbl_lsb_done_late", 32'(lsb_done), 32'd0);
      chk("f3_grant", 32'(mc_if_en), 32'd1);
      chk("f3_pc", mc_if_pc, 32'h3000);
      mc_if_done = 1'b1; mc_if_data = 32'h55667788;
      step();
      mc_if_done = 1'b0;
      chk("f3_done", 32'(if_done), 32'd1);
      chk("f3_data", if_data, 32'h55667788);
      if_addr = 32'h4000;
      step();

      // Rollback during a fetch: word is discarded
      step();
      chk("rbf_grant", 32'(mc_if_en), 32'd1);
      rollback = 1'b1;
      step();
      rollback = 1'b0; if_req = 1'b0;
      chk("rbf_en_held", 32'(mc_if_en), 32'd1);
      step();
      chk("rbf_en_held2", 32'(mc_if_en), 32'd1);
      mc_if_done = 1'b1; mc_if_data = 32'h99999999;
      step();
      mc_if_done = 1'b0;
      chk("rbf_en_drop", 32'(mc_if_en), 32'd0);
      chk("rbf_no_done", 32'(if_done), 32'd0);
      chk("rbf_data_kept", if_data, 32'h55667788);
      step();
      chk("rbf_no_done2", 32'(if_done), 32'd0);

      // Rollback in IDLE blocks the grant for that cycle
      if_req = 1'b1; if_addr = 32'h5000; rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("rbi_no_grant", 32'(mc_if_en), 32'd0);
      step();
      chk("rbi_grant_after", 32'(mc_if_en), 32'd1);
      mc_if_done = 1'b1; mc_if_data = 32'h0BADF00D;
      step();
      mc_if_done = 1'b0;
      chk("f5_data", if_data, 32'h0BADF00D);
      if_req = 1'b0;
      step();

      // Store survives rollback; stray fetch done is ignored; rdy freezes the pulse
      lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd4; lsb_wdata = 32'hCAFEF00D;
      step();
      chk("st_grant", 32'(mc_lsb_en), 32'd1);
      chk("st_wr", 32'(mc_lsb_wr), 32'd1);
      chk("st_addr", mc_lsb_addr, 32'h30000);
      chk("st_wdata", mc_lsb_w_data, 32'hCAFEF00D);
      rollback = 1'b1; mc_if_done = 1'b1; mc_if_data = 32'h12345678;
      step();
      rollback = 1'b0; mc_if_done = 1'b0;
      chk("st_en_after_rb", 32'(mc_lsb_en), 32'd1);
      chk("st_stray_if_done", 32'(if_done), 32'd0);
      chk("st_stray_if_data", if_data, 32'h0BADF00D);
      mc_lsb_done = 1'b1;
      step();
      mc_lsb_done = 1'b0; lsb_req = 1'b0;
      chk("st_done", 32'(lsb_done), 32'd1);
      chk("st_en_drop", 32'(mc_lsb_en), 32'd0);
      rdy = 1'b0;
      step();
      chk("rdy_freeze_done", 32'(lsb_done), 32'd1);
      rdy = 1'b1;
      step();
      chk("st_done_pulse", 32'(lsb_done), 32'd0);
      step();

      // Contention: both requesters busy for ten grants
`ifdef MEM_ARB_AGING_EN
      exp_f = 10'b10_0001_0000;
`else
      exp_f = 10'b00_0000_0000;
`endif
      if_req = 1'b1; if_addr = 32'h6000;
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h80; lsb_len = 3'd4;
      for (int g = 0; g < 10; g++) begin
         waited = 0;
         while (!mc_if_en && !mc_lsb_en && waited < 10) begin
            step();
            waited++;
         end
         chk($sformatf("age_grant%0d_seen", g), 32'(mc_if_en | mc_lsb_en), 32'd1);
         chk($sformatf("age_grant%0d_is_fetch", g), 32'(mc_if_en), 32'(exp_f[g]));
         if (mc_if_en) mc_if_done = 1'b1;
         else mc_lsb_done = 1'b1;
         step();
         mc_if_done = 1'b0; mc_lsb_done = 1'b0;
         step();
      end
      if_req = 1'b0; lsb_req = 1'b0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Request scheduler in front of the byte-serial memory controller. Accepts one outstanding transaction from instruction fetch and one from the load/store buffer. Grants one at a time, holds the controller-side request stable until completion, and returns the result as a registered one-cycle done pulse. Handles rollback (cancels loads, discards in-flight fetch data, never cancels stores) and optionally ages fetch requests so a busy LSB cannot starve fetch.

## Interface
- AGE_LIMIT, 4: consecutive LSB grants allowed while if_req is pending (aging build only; 1..15).
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- rollback  in  1  pipeline flush
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle done pulse
- if_data  out  32  fetched word; valid with if_done, held until the next if_done
- lsb_req  in  1  LSB request; held until lsb_done
- lsb_wr  in  1  1 = store
- lsb_addr  in  32  byte address
- lsb_len  in  3  byte count, 1/2/4
- lsb_wdata  in  32  store data, little-endian
- lsb_done  out  1  one-cycle done pulse
- lsb_rdata  out  32  load data, zero-filled above lsb_len; valid with lsb_done
- mc_if_en / mc_if_pc  out  1 / 32  controller fetch request
- mc_if_done / mc_if_data  in  1 / 32  controller fetch completion
- mc_lsb_en, mc_lsb_wr, mc_lsb_addr, mc_lsb_len, mc_lsb_w_data  out  1,1,32,3,32  controller LSB request
- mc_lsb_done / mc_lsb_r_data  in  1 / 32  controller LSB completion

## Operation
- States: IDLE, BUSY_IF, BUSY_LD, BUSY_ST, DISCARD_IF, RESP.
- IDLE: no grant while rollback=1.
  - Otherwise lsb_req wins over if_req, except when aging forces fetch.
  - On grant, operands are latched into registers, the matching mc_*_en goes to 1, and the state moves to BUSY_*.
- BUSY_*: mc_*_en and the latched operands stay constant. On the matching mc_*_done:
  - mc_*_en goes to 0.
  - Result is captured into if_data / lsb_rdata.
  - Matching upstream done goes to 1.
  - State moves to RESP.
- RESP: dones return to 0 and the state moves to IDLE. No grant in RESP. This gives requesters one cycle to drop or replace req, and aligns with the controller's post-done idle cycle.
- Rollback in BUSY_LD: mc_lsb_en goes to 0, the state moves to IDLE, and no lsb_done is issued.
- Rollback in BUSY_IF: the state moves to DISCARD_IF with mc_if_en kept high. On mc_if_done, mc_if_en goes to 0 and the state moves to RESP, but if_done stays 0 and if_data is unchanged.
- Rollback in BUSY_ST, DISCARD_IF or RESP: no effect; the store always completes and reports lsb_done.
- Rollback in IDLE: nothing is granted that cycle.
- An mc_*_done that does not match the active state is ignored.
- lsb_rdata bytes above lsb_len are forced to 0 on capture.
- Reset (and outputs until the first grant):
  - state=IDLE
  - all mc_*_en=0, if_done=0, lsb_done=0
  - if_data=0, lsb_rdata=0
  - mc_if_pc/mc_lsb_addr/mc_lsb_w_data=0, mc_lsb_len=0, mc_lsb_wr=0
  - age counter=0

## Timing
- Request sampled at edge N in IDLE → mc_*_en high from N (registered; the controller sees it in cycle N+1).
- mc_*_done high in cycle D → upstream done high in cycle D+1 for exactly one cycle.
- Earliest next grant is at the edge ending cycle D+2.
- A requester holding req after its done is a new request; it is sampled no earlier than D+2.
- Throughput: at most one transaction per (controller latency + 2) cycles.
- rdy=0 freezes everything, including the age counter and done pulses.

## Configuration
- MEM_ARB_AGING_EN defined:
  - A 4-bit age counter increments on each LSB grant made while if_req=1.
  - It clears on any fetch grant and whenever if_req=0 in IDLE.
  - When the counter equals AGE_LIMIT, the next IDLE grant goes to fetch if if_req=1, even with lsb_req=1.
- Undefined: strict LSB priority; no counter.

## Test plan
- Reset, then if_req with if_addr=0x1000 → mc_if_en=1 with mc_if_pc=0x1000 next cycle. Model returns 0xDEADBEEF → if_done pulse of 1 cycle with if_data=0xDEADBEEF.
- if_req and lsb_req in the same cycle (load, len=2, addr=0x20) → LSB granted first. Model bytes 0xAA,0xBB,0xCC,0xDD → lsb_rdata=0x0000BBAA. Fetch is granted at D+2.
- Rollback during a 4-byte load → no lsb_done, mc_lsb_en drops the next cycle. A new fetch is then granted normally.
- Rollback during a fetch → mc_if_en held until mc_if_done, if_done never asserted, if_data keeps its previous value.
- Rollback during a store to 0x30000 → the store completes and lsb_done pulses once.
- With MEM_ARB_AGING_EN and AGE_LIMIT=4, continuous lsb_req plus if_req → grant order L,L,L,L,F,L,L,L,L,F. Without the macro, fetch is never granted.
